result_display_seq: RTL and testbench
=====================================

RESULT_DISPLAY_SEQ -- requirements
Module: result_display_seq

Interface
REQ-001 Parameter MAX_COUNT, default 24'd10_000_000, clock cycles each display phase lasts; legal range 1..2^24-1.
REQ-002 clk  input  1  single system clock; all state updates on its rising edge.
REQ-003 rst_n  input  1  reset, asynchronous, active-low.
REQ-004 ena  input  1  design enable; high = run, low = freeze.
REQ-005 result  input  6  unsigned product word from the matrix-vector multiplier stage.
REQ-006 result_valid  input  1  single-cycle strobe; result is captured when high.
REQ-007 seg  output  7  seven-segment drive, active-high, seg[0]=a ... seg[6]=g.
REQ-008 dp  output  1  decimal point, active-high; marks the high digit.
REQ-009 busy  output  1  high while a captured value is being displayed (any state other than IDLE).

Function
REQ-010 The block SHALL implement states IDLE, SHOW_HI, SHOW_LO and GAP, held in a state register.
REQ-011 A 24-bit phase counter SHALL count 0..MAX_COUNT-1 while ena=1 and state!=IDLE; tick = counter equals MAX_COUNT-1 with ena=1.
REQ-012 On tick the counter SHALL return to 0 and the state SHALL advance SHOW_HI->SHOW_LO->GAP->SHOW_HI; outside a tick the state SHALL hold.
REQ-013 A cycle with result_valid=1 and ena=1 SHALL load result into a 6-bit capture register, clear the counter and force the state to SHOW_HI, overriding any simultaneous tick.
REQ-014 result_valid while ena=0 SHALL be ignored.
REQ-015 While ena=0 the counter, state and capture register SHALL hold their values, and seg and dp SHALL read 0.
REQ-016 seg and dp SHALL be decoded combinationally from the state and capture registers, so the display reflects a capture in the cycle after the strobe.
REQ-017 SHOW_HI SHALL display hex digit {2'b00, cap[5:4]} with dp=1.
REQ-018 SHOW_LO SHALL display hex digit cap[3:0] with dp=0.
REQ-019 IDLE and GAP SHALL drive seg=0 and dp=0.
REQ-020 Hex encoding (g..a, hex) SHALL be 0:3F 1:06 2:5B 3:4F 4:66 5:6D 6:7D 7:07 8:7F 9:6F A:77 b:7C C:39 d:5E E:79 F:71.
REQ-021 With MAX_COUNT=1 every enabled cycle SHALL be a tick, and each phase SHALL last exactly one cycle.
REQ-022 The sequence SHALL repeat indefinitely until reset; a new strobe restarts it at SHOW_HI with the new value.

Reset
REQ-023 While rst_n=0 the state SHALL be IDLE, the counter 0 and the capture register 0, so seg=0, dp=0 and busy=0, independent of clk.
REQ-024 Assertion of rst_n mid-phase SHALL abort the sequence immediately.
REQ-025 After release the block SHALL stay in IDLE until the first enabled strobe.

Structure
REQ-026 A shared package SHALL hold the state enumeration, the 16-entry segment constant table and the counter width (24).
REQ-027 Hex-to-segment decoding SHALL live in a combinational sub-module hex_to_seg7 (4-bit in, 7-bit out), instantiated once and fed by a digit multiplexer.
REQ-028 No other sub-modules are required.

Verification (MAX_COUNT=4 unless noted)
REQ-029 Reset release, no strobe, 20 cycles -> seg=00, dp=0, busy=0 throughout.
REQ-030 Strobe result=6'h2B (43) -> next cycle seg=5B with dp=1 for 4 cycles, then seg=7C with dp=0 for 4 cycles, then seg=00 for 4 cycles, then seg=5B again.
REQ-031 Strobe result=6'h05, then strobe 6'h3F during SHOW_LO -> next cycle seg=4F with dp=1, counter restarted, then seg=71.
REQ-032 Strobe coincident with a tick -> the state goes to SHOW_HI with the counter at 0, not the tick's successor state.
REQ-033 ena=0 for 10 cycles mid-SHOW_LO -> seg=00 and dp=0; on ena=1 the display resumes SHOW_LO with its remaining cycles intact; a strobe during ena=0 is ignored.
REQ-034 rst_n asserted asynchronously mid-GAP (MAX_COUNT=1 and MAX_COUNT=4) -> seg=00 and busy=0 before the next clk edge; the captured value is cleared.

Source files
------------

// File: rtl/result_display_seq_pkg.sv
`default_nettype none
// ============================================================================
// Module      : result_display_seq_pkg
// Description : Shared definitions for the result display sequencer: the
//               display state enumeration, the phase counter width and the
//               hex-to-seven-segment constant table.
// Revision    : 1.0 - initial release
// ============================================================================
package result_display_seq_pkg;

    // Width of the per-phase cycle counter.
    localparam int CNT_W = 24;

    // Display sequence states.
    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_SHOW_HI = 2'd1,
        ST_SHOW_LO = 2'd2,
        ST_GAP     = 2'd3
    } state_t;

    // Segment patterns indexed by hex digit; bit order is g..a, active-high.
    // Listed from digit F down to digit 0, so SEG_TABLE[0] is the pattern
    // for '0'.
    localparam logic [15:0][6:0] SEG_TABLE = {
        7'h71, 7'h79, 7'h5E, 7'h39,   // F E d C
        7'h7C, 7'h77, 7'h6F, 7'h7F,   // b A 9 8
        7'h07, 7'h7D, 7'h6D, 7'h66,   // 7 6 5 4
        7'h4F, 7'h5B, 7'h06, 7'h3F    // 3 2 1 0
    };

    // Successor of a display phase on a tick. IDLE only leaves via a strobe,
    // so it maps to itself.
    function automatic state_t next_phase(input state_t s);
        state_t n;
        n = s;
        case (s)
            ST_SHOW_HI: n = ST_SHOW_LO;
            ST_SHOW_LO: n = ST_GAP;
            ST_GAP:     n = ST_SHOW_HI;
            default:    n = s;
        endcase
        return n;
    endfunction

endpackage : result_display_seq_pkg
`default_nettype wire

// File: rtl/result_display_seq_hex_to_seg7.sv
`default_nettype none
// ============================================================================
// Module      : hex_to_seg7
// Description : Combinational hex digit to seven-segment decoder.
// Ports       : hex_i [3:0] - hex digit to display
//               seg_o [6:0] - segment drive, active-high, seg_o[0]=a..[6]=g
// Revision    : 1.0 - initial release
// ============================================================================
module hex_to_seg7
    import result_display_seq_pkg::*;
(
    input  logic [3:0] hex_i,
    output logic [6:0] seg_o
);

    assign seg_o = SEG_TABLE[hex_i];

endmodule : hex_to_seg7
`default_nettype wire

// File: rtl/result_display_seq.sv
`default_nettype none
// ============================================================================
// Module      : result_display_seq
// Description : Captures a 6-bit product word on a valid strobe and shows it
//               on one seven-segment digit as a repeating sequence:
//               high digit (with decimal point), low digit, blank gap.
//               Each phase lasts MAX_COUNT enabled clock cycles.
// Ports       : clk          - system clock, rising edge
//               rst_n        - asynchronous active-low reset
//               ena          - enable; low freezes all state and blanks display
//               result [5:0] - product word to capture
//               result_valid - single-cycle capture strobe
//               seg [6:0]    - segment drive, active-high, seg[0]=a..seg[6]=g
//               dp           - decimal point, high while showing high digit
//               busy         - high whenever a captured value is in sequence
// Revision    : 1.0 - initial release
// ============================================================================
module result_display_seq
    import result_display_seq_pkg::*;
#(
    parameter logic [CNT_W-1:0] MAX_COUNT = 24'd10_000_000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       ena,
    input  logic [5:0] result,
    input  logic       result_valid,
    output logic [6:0] seg,
    output logic       dp,
    output logic       busy
);

    localparam logic [CNT_W-1:0] C_LAST = MAX_COUNT - CNT_W'(1);

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q,   cnt_d;
    logic [5:0]       cap_q,   cap_d;

    logic             tick;
    logic [3:0]       digit;
    logic [6:0]       seg_raw;

    // ------------------------------------------------------------------
    // State, counter and capture registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            cap_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            cap_q   <= cap_d;
        end
    end

    // A phase ends on its last enabled cycle. With MAX_COUNT=1 the counter
    // stays at 0, so every enabled non-idle cycle is a tick.
    assign tick = ena && (state_q != ST_IDLE) && (cnt_q == C_LAST);

    // ------------------------------------------------------------------
    // Next-state logic. A strobe takes priority over a coincident tick so
    // a fresh value always starts from the beginning of the high phase.
    // ------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        cap_d   = cap_q;

        if (ena) begin
            if (result_valid) begin
                cap_d   = result;
                cnt_d   = '0;
                state_d = ST_SHOW_HI;
            end else if (state_q != ST_IDLE) begin
                if (tick) begin
                    cnt_d   = '0;
                    state_d = next_phase(state_q);
                end else begin
                    cnt_d   = cnt_q + CNT_W'(1);
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Digit multiplexer feeding the single decoder
    // ------------------------------------------------------------------
    always_comb begin
        digit = cap_q[3:0];
        if (state_q == ST_SHOW_HI) begin
            digit = {2'b00, cap_q[5:4]};
        end
    end

    hex_to_seg7 u_hex_to_seg7 (
        .hex_i (digit),
        .seg_o (seg_raw)
    );

    // ------------------------------------------------------------------
    // Output drive: blanked while disabled and in IDLE/GAP
    // ------------------------------------------------------------------
    always_comb begin
        seg  = '0;
        dp   = 1'b0;
        busy = (state_q != ST_IDLE);
        if (ena) begin
            case (state_q)
                ST_SHOW_HI: begin
                    seg = seg_raw;
                    dp  = 1'b1;
                end
                ST_SHOW_LO: begin
                    seg = seg_raw;
                end
                default: begin
                    seg = '0;
                    dp  = 1'b0;
                end
            endcase
        end
    end

endmodule : result_display_seq
`default_nettype wire

// File: tb/tb_result_display_seq.sv
`default_nettype none
// ============================================================================
// Module      : tb_result_display_seq
// Description : Self-checking bench for result_display_seq. Two instances
//               (MAX_COUNT=4 and MAX_COUNT=1) share one stimulus stream and
//               are compared every cycle against a timeline model, alongside
//               hand-computed literal expectations for the MAX_COUNT=4 part.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_result_display_seq;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       ena = 1'b0;
    logic       result_valid = 1'b0;
    logic [5:0] result = 6'h00;

    logic [6:0] seg4, seg1;
    logic       dp4, dp1, busy4, busy1;

    int unsigned pass_cnt  = 0;
    int unsigned total_cnt = 0;
    bit          cmp_on    = 1'b0;

    always #5 clk = ~clk;

    result_display_seq #(.MAX_COUNT(24'd4)) dut4 (
        .clk          (clk),
        .rst_n        (rst_n),
        .ena          (ena),
        .result       (result),
        .result_valid (result_valid),
        .seg          (seg4),
        .dp           (dp4),
        .busy         (busy4)
    );

    result_display_seq #(.MAX_COUNT(24'd1)) dut1 (
        .clk          (clk),
        .rst_n        (rst_n),
        .ena          (ena),
        .result       (result),
        .result_valid (result_valid),
        .seg          (seg1),
        .dp           (dp1),
        .busy         (busy1)
    );

    // Segment patterns written out from the hex encoding table.
    logic [6:0] seg_tab [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                                 7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

    // Timeline model: after a capture, t counts enabled cycles; the phase is
    // floor(t / MAX_COUNT) mod 3 (0 = high digit, 1 = low digit, 2 = gap).
    bit          act4 = 1'b0, act1 = 1'b0;
    int unsigned t4 = 0, t1 = 0;
    logic [5:0]  cap4 = 6'h00, cap1 = 6'h00;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            act4 <= 1'b0; act1 <= 1'b0;
            t4   <= 0;    t1   <= 0;
            cap4 <= 6'h00; cap1 <= 6'h00;
        end else if (ena) begin
            if (result_valid) begin
                act4 <= 1'b1; act1 <= 1'b1;
                t4   <= 0;    t1   <= 0;
                cap4 <= result; cap1 <= result;
            end else begin
                if (act4) t4 <= t4 + 1;
                if (act1) t1 <= t1 + 1;
            end
        end
    end

    // Returns {busy, dp, seg}.
    function automatic logic [8:0] exp_out(input bit act, input int unsigned t,
                                           input int unsigned mc, input logic [5:0] cap,
                                           input logic en);
        int unsigned ph;
        logic [6:0]  s;
        logic        d;
        ph = (t / mc) % 3;
        s  = 7'h00;
        d  = 1'b0;
        if (act && en) begin
            if (ph == 0) begin
                s = seg_tab[int'(cap) / 16];
                d = 1'b1;
            end else if (ph == 1) begin
                s = seg_tab[int'(cap) % 16];
            end
        end
        return {act, d, s};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        total_cnt++;
        if (act !== req) begin
            $display("FAIL %s: actual=0x%0h required=0x%0h (t=%0t)", name, act, req, $time);
        end else begin
            pass_cnt++;
        end
    endtask

    // Per-cycle comparison, sampled on the falling edge.
    always @(negedge clk) begin
        if (cmp_on) begin
            logic [8:0] e4, e1;
            e4 = exp_out(act4, t4, 4, cap4, ena);
            e1 = exp_out(act1, t1, 1, cap1, ena);
            check("mc4_seg",  {25'd0, seg4}, {25'd0, e4[6:0]});
            check("mc4_dp",   {31'd0, dp4},   {31'd0, e4[7]});
            check("mc4_busy", {31'd0, busy4}, {31'd0, e4[8]});
            check("mc1_seg",  {25'd0, seg1}, {25'd0, e1[6:0]});
            check("mc1_dp",   {31'd0, dp1},   {31'd0, e1[7]});
            check("mc1_busy", {31'd0, busy1}, {31'd0, e1[8]});
        end
    end

    // Advance n rising edges and settle 2 time units after the last one.
    task automatic tick_n(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    task automatic strobe(input logic [5:0] v);
        result       = v;
        result_valid = 1'b1;
        tick_n(1);
        result_valid = 1'b0;
    endtask

    // Literal expectation for the MAX_COUNT=4 instance.
    task automatic lit4(input string name, input logic [6:0] es, input logic ed, input logic eb);
        #1;
        check({name, "_seg"},  {25'd0, seg4},  {25'd0, es});
        check({name, "_dp"},   {31'd0, dp4},   {31'd0, ed});
        check({name, "_busy"}, {31'd0, busy4}, {31'd0, eb});
    endtask

    task automatic async_reset(input string name);
        rst_n = 1'b0;
        #1;
        check({name, "_seg4"},  {25'd0, seg4},  32'h0);
        check({name, "_busy4"}, {31'd0, busy4}, 32'h0);
        check({name, "_seg1"},  {25'd0, seg1},  32'h0);
        check({name, "_busy1"}, {31'd0, busy1}, 32'h0);
        check({name, "_cap4"},  {26'd0, dut4.cap_q}, 32'h0);
        check({name, "_cap1"},  {26'd0, dut1.cap_q}, 32'h0);
        tick_n(2);
        rst_n = 1'b1;
        tick_n(5);
        lit4({name, "_idle"}, 7'h00, 1'b0, 1'b0);
    endtask

    initial begin
        ena = 1'b1;
        tick_n(2);
        cmp_on = 1'b1;
        lit4("in_reset", 7'h00, 1'b0, 1'b0);
        rst_n = 1'b1;

        // Idle after release, no strobe
        tick_n(20);
        lit4("idle20", 7'h00, 1'b0, 1'b0);

        // Basic sequence for 0x2B
        strobe(6'h2B);
        lit4("hi2B", 7'h5B, 1'b1, 1'b1);
        tick_n(3);
        lit4("hi2B_last", 7'h5B, 1'b1, 1'b1);
        tick_n(1);
        lit4("lo2B", 7'h7C, 1'b0, 1'b1);
        tick_n(4);
        lit4("gap2B", 7'h00, 1'b0, 1'b1);
        tick_n(4);
        lit4("hi2B_again", 7'h5B, 1'b1, 1'b1);

        // Restrobe during the low phase
        strobe(6'h05);
        tick_n(4);
        lit4("lo05", 7'h6D, 1'b0, 1'b1);
        strobe(6'h3F);
        lit4("restart3F", 7'h4F, 1'b1, 1'b1);
        tick_n(4);
        lit4("lo3F", 7'h71, 1'b0, 1'b1);

        // Strobe coincident with the end-of-phase tick
        strobe(6'h05);
        tick_n(3);
        strobe(6'h12);
        check("tick_strobe_cnt", {8'd0, dut4.cnt_q}, 32'h0);
        lit4("tick_strobe_hi", 7'h06, 1'b1, 1'b1);
        tick_n(3);
        lit4("tick_strobe_hi_last", 7'h06, 1'b1, 1'b1);
        tick_n(1);
        lit4("tick_strobe_lo", 7'h5B, 1'b0, 1'b1);

        // Freeze mid low phase, with an ignored strobe while disabled
        strobe(6'h2B);
        tick_n(5);
        ena = 1'b0;
        lit4("frozen", 7'h00, 1'b0, 1'b1);
        tick_n(3);
        result       = 6'h3F;
        result_valid = 1'b1;
        tick_n(1);
        result_valid = 1'b0;
        tick_n(6);
        lit4("frozen_end", 7'h00, 1'b0, 1'b1);
        ena = 1'b1;
        lit4("resume", 7'h7C, 1'b0, 1'b1);
        tick_n(2);
        lit4("resume_last", 7'h7C, 1'b0, 1'b1);
        tick_n(1);
        lit4("resume_gap", 7'h00, 1'b0, 1'b1);

        // Asynchronous reset mid gap: MAX_COUNT=4 instance in gap (t=9)
        strobe(6'h2B);
        tick_n(9);
        lit4("pre_rst4_gap", 7'h00, 1'b0, 1'b1);
        async_reset("rst_gap4");

        // Asynchronous reset mid gap: MAX_COUNT=1 instance in gap (t=8)
        strobe(6'h2B);
        tick_n(8);
        #1;
        check("pre_rst1_seg",  {25'd0, seg1},  32'h0);
        check("pre_rst1_busy", {31'd0, busy1}, 32'h1);
        async_reset("rst_gap1");

        cmp_on = 1'b0;
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule : tb_result_display_seq
`default_nettype wire
